buffer_fifo_ctrl: RTL and testbench

Pointer and flag controller that turns the 64×24 dual-port buffer memory into a synchronous FIFO. It accepts push/pop requests from the producer and consumer sides and drives the memory's write/read pointers and enables. It also reports occupancy, full/empty/almost-full status and sticky overflow/underflow errors. It instantiates the memory internally, so the rest of the memory controller sees a single FIFO block.

---
 rtl/buffer_fifo_pkg.sv | 35 +++
 rtl/buffer_fifo_ctrl_if.sv | 35 +++
 rtl/BufferFIFOMemory.sv | 36 +++
 rtl/buffer_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_buffer_fifo_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_fifo_pkg.sv
// ---------------------------------------------------------------------------
// buffer_fifo_pkg
// Shared constants and types for the buffer FIFO controller and the memory
// controller that reads its status.
//   DATA_W  : data word width (matches the 64x24 buffer memory)
//   ADDR_W  : pointer width, DEPTH = 2**ADDR_W
//   CNT_W   : occupancy width, wide enough to hold 0..DEPTH
//   status_t: FIFO status as exposed to the memory controller status register
// ---------------------------------------------------------------------------
package buffer_fifo_pkg;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic             full;
        logic             empty;
        logic             almost_full;
        logic             overflow;
        logic             underflow;
    } status_t;

    localparam status_t STATUS_RESET = '{
        count:       '0,
        full:        1'b0,
        empty:       1'b1,
        almost_full: 1'b0,
        overflow:    1'b0,
        underflow:   1'b0
    };

endpackage

// File: rtl/buffer_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// buffer_fifo_ctrl_if
// Producer/consumer side of the buffer FIFO.
//   master: drives push/wr_data/pop/clr_err, observes data and status
//   slave : the FIFO controller
// ---------------------------------------------------------------------------
interface buffer_fifo_ctrl_if;
    import buffer_fifo_pkg::*;

    logic              push;
    logic [DATA_W-1:0] wr_data;
    logic              pop;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, wr_data, pop, clr_err,
        input  rd_data, rd_valid, count, full, empty, almost_full,
               overflow, underflow
    );

    modport slave (
        input  push, wr_data, pop, clr_err,
        output rd_data, rd_valid, count, full, empty, almost_full,
               overflow, underflow
    );

endinterface

// File: rtl/BufferFIFOMemory.sv
// ---------------------------------------------------------------------------
// BufferFIFOMemory
// 2**ADDR_W x DATA_W simple dual-port buffer memory, one clock.
//   clk    : clock
//   wren   : write enable, wrptr/wrdata written at the rising edge
//   rden   : read enable, rddata updated from rdptr at the rising edge
//   rddata : registered read data; a same-address write in the same cycle
//            returns the old word (read happens before the write lands)
// ---------------------------------------------------------------------------
module BufferFIFOMemory #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wrptr,
    input  logic [DATA_W-1:0] wrdata,
    input  logic              rden,
    input  logic [ADDR_W-1:0] rdptr,
    output logic [DATA_W-1:0] rddata
);

    logic [DATA_W-1:0] mem_q [1 << ADDR_W];

    // NOTE: the storage array has no reset; contents after reset are garbage
    // and only words written since then are ever read back as valid.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem_q[wrptr] <= wrdata;
        end
        if (rden) begin
            rddata <= mem_q[rdptr];
        end
    end

endmodule

// File: rtl/buffer_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// buffer_fifo_ctrl
// Pointer, occupancy and flag controller wrapping BufferFIFOMemory into a
// synchronous FIFO with 1-cycle read latency.
//   memclk : single clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : producer/consumer port (push/wr_data/pop/clr_err in; rd_data,
//            rd_valid, count, full, empty, almost_full, overflow, underflow out)
// ---------------------------------------------------------------------------
module buffer_fifo_ctrl
    import buffer_fifo_pkg::*;
#(
    parameter int AFULL_TH = 56
) (
    input  logic               memclk,
    input  logic               reset,
    buffer_fifo_ctrl_if.slave  bus
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    status_t           status_q, status_d;
    logic              rd_valid_q;
    logic              pop_ok;
    logic              push_ok;

    // Accept decisions use registered flags only. When full, a push rides on
    // an accepted pop; when empty, a pop is never bypassed from a push.
    assign pop_ok  = bus.pop & ~status_q.empty;
    assign push_ok = bus.push & (~status_q.full | pop_ok);

    // NOTE: every next-state signal gets a default first so this block can
    // never infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        status_d = status_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        unique case ({push_ok, pop_ok})
            2'b10:   status_d.count = status_q.count + CNT_W'(1);
            2'b01:   status_d.count = status_q.count - CNT_W'(1);
            default: status_d.count = status_q.count;
        endcase

        // Flags decode the next count so they are registered alongside it.
        status_d.full        = (status_d.count == CNT_W'(DEPTH));
        status_d.empty       = (status_d.count == '0);
        status_d.almost_full = (status_d.count >= CNT_W'(AFULL_TH));

        // clr_err wins over a same-cycle error event.
        if (bus.clr_err) begin
            status_d.overflow  = 1'b0;
            status_d.underflow = 1'b0;
        end else begin
            status_d.overflow  = status_q.overflow
                               | (bus.push & status_q.full & ~pop_ok);
            status_d.underflow = status_q.underflow
                               | (bus.pop & status_q.empty & ~bus.push);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge memclk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            status_q   <= STATUS_RESET;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            status_q   <= status_d;
            rd_valid_q <= pop_ok;
        end
    end

    BufferFIFOMemory #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (memclk),
        .wren   (push_ok),
        .wrptr  (wr_ptr_q),
        .wrdata (bus.wr_data),
        .rden   (pop_ok),
        .rdptr  (rd_ptr_q),
        .rddata (bus.rd_data)
    );

    assign bus.rd_valid    = rd_valid_q;
    assign bus.count       = status_q.count;
    assign bus.full        = status_q.full;
    assign bus.empty       = status_q.empty;
    assign bus.almost_full = status_q.almost_full;
    assign bus.overflow    = status_q.overflow;
    assign bus.underflow   = status_q.underflow;

endmodule

// File: tb/tb_buffer_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_buffer_fifo_ctrl
// Self-checking bench for buffer_fifo_ctrl. A queue model of the FIFO
// predicts occupancy and flags; words leaving the model are pushed to a
// scoreboard and compared when the DUT raises rd_valid.
// ---------------------------------------------------------------------------
module tb_buffer_fifo_ctrl;
    import buffer_fifo_pkg::*;

    logic memclk = 1'b0;
    logic reset;

    always #5 memclk = ~memclk;

    buffer_fifo_ctrl_if bus ();

    buffer_fifo_ctrl #(.AFULL_TH(56)) dut (
        .memclk (memclk),
        .reset  (reset),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] exp_q   [$];
    bit                m_over;
    bit                m_under;

    // One clock cycle: drive inputs, advance the model, wait past the edge,
    // then check rd_valid/rd_data against the scoreboard and the full status
    // against the model.
    task automatic tick(input bit p, input logic [DATA_W-1:0] d,
                        input bit q, input bit c, input bit r);
        bit      pop_ok;
        bit      push_ok;
        int      sz;
        status_t exp_s;
        status_t obs_s;
        logic [DATA_W-1:0] exp_d;

        bus.push    = p;
        bus.wr_data = d;
        bus.pop     = q;
        bus.clr_err = c;
        reset       = r;

        sz = model_q.size();
        if (r) begin
            pop_ok  = 1'b0;
            push_ok = 1'b0;
            model_q.delete();
            exp_q.delete();
            m_over  = 1'b0;
            m_under = 1'b0;
        end else begin
            pop_ok  = q && (sz != 0);
            push_ok = p && ((sz != DEPTH) || pop_ok);
            if (c) begin
                m_over  = 1'b0;
                m_under = 1'b0;
            end else begin
                m_over  = m_over  | (p && (sz == DEPTH) && !pop_ok);
                m_under = m_under | (q && (sz == 0) && !p);
            end
            if (pop_ok)  exp_q.push_back(model_q.pop_front());
            if (push_ok) model_q.push_back(d);
        end

        @(posedge memclk);
        #1;

        n_checks++;
        if (bus.rd_valid !== pop_ok)
            $display("FAIL rd_valid: got %b want %b at %0t", bus.rd_valid, pop_ok, $time);
        else
            n_pass++;

        if (bus.rd_valid === 1'b1 && pop_ok) begin
            exp_d = exp_q.pop_front();
            n_checks++;
            if (bus.rd_data !== exp_d)
                $display("FAIL rd_data: got %06h want %06h at %0t", bus.rd_data, exp_d, $time);
            else
                n_pass++;
        end

        sz = model_q.size();
        exp_s.count       = CNT_W'(sz);
        exp_s.full        = (sz == DEPTH);
        exp_s.empty       = (sz == 0);
        exp_s.almost_full = (sz >= 56);
        exp_s.overflow    = m_over;
        exp_s.underflow   = m_under;
        obs_s.count       = bus.count;
        obs_s.full        = bus.full;
        obs_s.empty       = bus.empty;
        obs_s.almost_full = bus.almost_full;
        obs_s.overflow    = bus.overflow;
        obs_s.underflow   = bus.underflow;
        n_checks++;
        if (obs_s !== exp_s)
            $display("FAIL status: got cnt=%0d f=%b e=%b af=%b ov=%b un=%b want cnt=%0d f=%b e=%b af=%b ov=%b un=%b at %0t",
                     obs_s.count, obs_s.full, obs_s.empty, obs_s.almost_full, obs_s.overflow, obs_s.underflow,
                     exp_s.count, exp_s.full, exp_s.empty, exp_s.almost_full, exp_s.overflow, exp_s.underflow, $time);
        else
            n_pass++;

        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic test_reset();
        tick(0, '0, 0, 0, 1);
        n_checks++;
        if (bus.count !== 7'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0)
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b want cnt=0 e=1 f=0", bus.count, bus.empty, bus.full);
        else
            n_pass++;
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.almost_full !== 1'b0)
            $display("FAIL reset_misc: got v=%b ov=%b un=%b af=%b want all 0",
                     bus.rd_valid, bus.overflow, bus.underflow, bus.almost_full);
        else
            n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 64; i++) begin
            tick(1, DATA_W'(i), 0, 0, 0);
            if (i == 55 || i == 56) begin
                n_checks++;
                if (bus.almost_full !== (i == 56))
                    $display("FAIL fill_afull: got %b want %b at count %0d", bus.almost_full, (i == 56), i);
                else
                    n_pass++;
            end
            if (i == 63) begin
                n_checks++;
                if (bus.full !== 1'b0)
                    $display("FAIL fill_full63: got %b want 0", bus.full);
                else
                    n_pass++;
            end
        end
        n_checks++;
        if (bus.full !== 1'b1 || bus.count !== 7'd64)
            $display("FAIL fill_full: got f=%b cnt=%0d want f=1 cnt=64", bus.full, bus.count);
        else
            n_pass++;
        tick(1, 24'h000041, 0, 0, 0);
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 7'd64)
            $display("FAIL fill_overflow: got ov=%b cnt=%0d want ov=1 cnt=64", bus.overflow, bus.count);
        else
            n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 64; i++) tick(0, '0, 1, 0, 0);
        n_checks++;
        if (bus.empty !== 1'b1 || bus.count !== 7'd0)
            $display("FAIL drain_empty: got e=%b cnt=%0d want e=1 cnt=0", bus.empty, bus.count);
        else
            n_pass++;
        tick(0, '0, 1, 0, 0);
        n_checks++;
        if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0)
            $display("FAIL drain_underflow: got un=%b v=%b want un=1 v=0", bus.underflow, bus.rd_valid);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        tick(0, '0, 0, 1, 0);
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
            $display("FAIL b2b_clr: got ov=%b un=%b want 0 0", bus.overflow, bus.underflow);
        else
            n_pass++;
        for (int i = 0; i < 3; i++) tick(1, DATA_W'(24'h100 + i), 0, 0, 0);
        for (int i = 0; i < 200; i++) tick(1, DATA_W'($urandom()), 1, 0, 0);
        n_checks++;
        if (bus.count !== 7'd3)
            $display("FAIL b2b_count: got %0d want 3", bus.count);
        else
            n_pass++;
        for (int i = 0; i < 3; i++) tick(0, '0, 1, 0, 0);
    endtask

    task automatic test_simultaneous();
        tick(0, '0, 0, 0, 1);
        tick(1, 24'h5A5A5A, 1, 0, 0);
        n_checks++;
        if (bus.count !== 7'd1 || bus.rd_valid !== 1'b0 || bus.underflow !== 1'b0)
            $display("FAIL simul_empty: got cnt=%0d v=%b un=%b want cnt=1 v=0 un=0",
                     bus.count, bus.rd_valid, bus.underflow);
        else
            n_pass++;
        for (int i = 0; i < 63; i++) tick(1, DATA_W'(24'h200 + i), 0, 0, 0);
        tick(1, 24'hABCDEF, 1, 0, 0);
        n_checks++;
        if (bus.rd_data !== 24'h5A5A5A || bus.count !== 7'd64 || bus.overflow !== 1'b0)
            $display("FAIL simul_full: got d=%06h cnt=%0d ov=%b want d=5a5a5a cnt=64 ov=0",
                     bus.rd_data, bus.count, bus.overflow);
        else
            n_pass++;
        for (int i = 0; i < 64; i++) tick(0, '0, 1, 0, 0);
    endtask

    task automatic test_reset_mid();
        tick(0, '0, 0, 0, 1);
        for (int i = 0; i < 10; i++) tick(1, DATA_W'(24'h300 + i), 0, 0, 0);
        tick(0, '0, 1, 0, 0);
        tick(0, '0, 1, 0, 1);
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 7'd0 || bus.empty !== 1'b1)
            $display("FAIL rstmid_state: got v=%b cnt=%0d e=%b want v=0 cnt=0 e=1",
                     bus.rd_valid, bus.count, bus.empty);
        else
            n_pass++;
        n_checks++;
        if (dut.wr_ptr_q !== 6'd0 || dut.rd_ptr_q !== 6'd0)
            $display("FAIL rstmid_ptrs: got wr=%0d rd=%0d want 0 0", dut.wr_ptr_q, dut.rd_ptr_q);
        else
            n_pass++;
        tick(0, '0, 0, 0, 0);
        tick(1, 24'h123456, 0, 0, 0);
        tick(0, '0, 1, 0, 0);
        tick(0, '0, 0, 0, 0);
    endtask

    task automatic test_clr_err();
        for (int i = 0; i < 64; i++) tick(1, DATA_W'(24'h400 + i), 0, 0, 0);
        tick(1, 24'hDEAD01, 0, 0, 0);
        n_checks++;
        if (bus.overflow !== 1'b1)
            $display("FAIL clr_set: got ov=%b want 1", bus.overflow);
        else
            n_pass++;
        tick(1, 24'hDEAD02, 0, 1, 0);
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.count !== 7'd64)
            $display("FAIL clr_priority: got ov=%b cnt=%0d want ov=0 cnt=64", bus.overflow, bus.count);
        else
            n_pass++;
        tick(1, 24'hDEAD03, 0, 0, 0);
        n_checks++;
        if (bus.overflow !== 1'b1)
            $display("FAIL clr_reset: got ov=%b want 1", bus.overflow);
        else
            n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        bus.push    = 1'b0;
        bus.wr_data = '0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        m_over      = 1'b0;
        m_under     = 1'b0;
        @(posedge memclk);
        #1;

        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        test_clr_err();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
